// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle between the pipeline/backing memory (master side) and the
// unified memory arbiter (slave side).
interface unified_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 30,
  parameter int unsigned CNT_W  = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [31:0]       if_rdata;
  logic              d_req;
  logic              d_we;
  logic [3:0]        d_be;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic [31:0]       d_rdata;
  logic              stall;
  logic              mem_req;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;
  logic [31:0]       mem_rdata;
  logic [CNT_W-1:0]  stall_cycles;

  modport master (
    output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_ready, mem_rdata,
    input  if_rdata, d_rdata, stall, mem_req, mem_we, mem_be, mem_addr, mem_wdata,
           stall_cycles
  );

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_ready, mem_rdata,
    output if_rdata, d_rdata, stall, mem_req, mem_we, mem_be, mem_addr, mem_wdata,
           stall_cycles
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Serialises the data and fetch requests of one pipeline step onto a single
// variable-latency memory port (data first), stalling the pipeline meanwhile.
module unified_mem_arbiter #(
  parameter int unsigned ADDR_W = 30,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  unified_mem_arbiter_if.slave  bus
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    D_ACC = 2'd1,
    F_ACC = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic              we;
    logic [BE_W-1:0]   be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } dreq_t;

  state_e            state_q, state_d;
  logic              f_pend_q, f_pend_d;
  logic [ADDR_W-1:0] f_addr_q, f_addr_d;
  dreq_t             dreq_q, dreq_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [BE_W-1:0]   mem_be_q, mem_be_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              stall_c;

  // Next-state, capture and memory-port drive; memory outputs are loaded for
  // the state being entered so they are registered yet aligned with it.
  always_comb begin
    state_d     = state_q;
    f_pend_d    = f_pend_q;
    f_addr_d    = f_addr_q;
    dreq_d      = dreq_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_be_d    = '0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    stall_c     = 1'b0;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.if_req || bus.d_req) begin
          stall_c      = 1'b1;
          f_pend_d     = bus.if_req;
          f_addr_d     = bus.if_addr;
          dreq_d.we    = bus.d_we;
          dreq_d.be    = bus.d_be;
          dreq_d.addr  = bus.d_addr;
          dreq_d.wdata = bus.d_wdata;
          mem_req_d    = 1'b1;
          if (bus.d_req) begin
            state_d     = D_ACC;
            mem_we_d    = bus.d_we;
            mem_be_d    = bus.d_be;
            mem_addr_d  = bus.d_addr;
            mem_wdata_d = bus.d_wdata;
          end else begin
            state_d    = F_ACC;
            mem_be_d   = 4'hF;
            mem_addr_d = bus.if_addr;
          end
        end
      end

      D_ACC: begin
        stall_c = 1'b1;
        if (bus.mem_ready) begin
          if (!dreq_q.we) begin
            d_rdata_d = bus.mem_rdata;
          end
          if (f_pend_q) begin
            state_d    = F_ACC;
            mem_req_d  = 1'b1;
            mem_be_d   = 4'hF;
            mem_addr_d = f_addr_q;
          end else begin
            state_d = DONE;
          end
        end else begin
          mem_req_d = 1'b1;
          mem_we_d  = dreq_q.we;
          mem_be_d  = dreq_q.be;
        end
      end

      F_ACC: begin
        stall_c = 1'b1;
        if (bus.mem_ready) begin
          if_rdata_d = bus.mem_rdata;
          state_d    = DONE;
        end else begin
          mem_req_d = 1'b1;
          mem_be_d  = 4'hF;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (stall_c && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      f_pend_q    <= 1'b0;
      f_addr_q    <= '0;
      dreq_q      <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      f_pend_q    <= f_pend_d;
      f_addr_q    <= f_addr_d;
      dreq_q      <= dreq_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.stall        = stall_c;
  assign bus.if_rdata     = if_rdata_q;
  assign bus.d_rdata      = d_rdata_q;
  assign bus.mem_req      = mem_req_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_be       = mem_be_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.stall_cycles = cnt_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: per-cycle vector table plus
// hand sequences for reset mid-transfer and stall-counter saturation.
module tb_unified_mem_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  unified_mem_arbiter_if #(.ADDR_W(30), .CNT_W(32)) bus0 ();
  unified_mem_arbiter_if #(.ADDR_W(30), .CNT_W(4))  bus1 ();

  unified_mem_arbiter #(.ADDR_W(30), .CNT_W(32)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  unified_mem_arbiter #(.ADDR_W(30), .CNT_W(4)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ifr;
    logic [29:0] ia;
    logic        dr;
    logic        we;
    logic [3:0]  be;
    logic [29:0] da;
    logic [31:0] wd;
    logic        rdy;
    logic [31:0] rd;
    logic        e_stall;
    logic        e_mreq;
    logic        e_mwe;
    logic [3:0]  e_mbe;
    logic [29:0] e_maddr;
    logic [31:0] e_mwd;
    logic [31:0] e_ifrd;
    logic [31:0] e_drd;
    logic [31:0] e_cnt;
  } vec_t;

  localparam int NV = 21;
  vec_t tbl [NV];

  function automatic vec_t mk(
    input logic ifr, input logic [29:0] ia, input logic dr, input logic we,
    input logic [3:0] be, input logic [29:0] da, input logic [31:0] wd,
    input logic rdy, input logic [31:0] rd,
    input logic st, input logic mr, input logic mw, input logic [3:0] mbe,
    input logic [29:0] ma, input logic [31:0] mwd, input logic [31:0] ifrd,
    input logic [31:0] drd, input logic [31:0] cnt);
    vec_t v;
    v.ifr = ifr; v.ia = ia; v.dr = dr; v.we = we; v.be = be; v.da = da;
    v.wd = wd; v.rdy = rdy; v.rd = rd;
    v.e_stall = st; v.e_mreq = mr; v.e_mwe = mw; v.e_mbe = mbe;
    v.e_maddr = ma; v.e_mwd = mwd; v.e_ifrd = ifrd; v.e_drd = drd; v.e_cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive0(input vec_t v);
    bus0.if_req    = v.ifr;
    bus0.if_addr   = v.ia;
    bus0.d_req     = v.dr;
    bus0.d_we      = v.we;
    bus0.d_be      = v.be;
    bus0.d_addr    = v.da;
    bus0.d_wdata   = v.wd;
    bus0.mem_ready = v.rdy;
    bus0.mem_rdata = v.rd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] WA = 32'h2402000A;
  localparam logic [31:0] WB = 32'hCAFE0001;
  localparam logic [31:0] WC = 32'h8C220000;
  localparam logic [31:0] WD = 32'h00001234;
  localparam logic [31:0] WS = 32'h00AB0000;

  initial begin
    vec_t z;
    checks = 0;
    errors = 0;

    // ifr ia dr we be da wd rdy rd | stall mreq mwe mbe maddr mwd ifrd drd cnt
    tbl[0]  = mk(1'b0, 30'h0, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0, 1'b0, 32'h0,
                 1'b0, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0, 32'h0, 32'h0, 32'd0);
    tbl[1]  = mk(1'b1, 30'h4, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0, 1'b1, WA,
                 1'b1, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0, 32'h0, 32'h0, 32'd0);
    tbl[2]  = mk(1'b1, 30'h4, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0, 1'b1, WA,
                 1'b1, 1'b1, 1'b0, 4'hF, 30'h4, 32'h0, 32'h0, 32'h0, 32'd1);
    tbl[3]  = mk(1'b0, 30'h0, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0, 1'b0, 32'h0,
                 1'b0, 1'b0, 1'b0, 4'h0, 30'h4, 32'h0, WA, 32'h0, 32'd2);
    tbl[4]  = mk(1'b1, 30'h8, 1'b1, 1'b0, 4'hF, 30'h100, 32'h0, 1'b0, 32'h0,
                 1'b1, 1'b0, 1'b0, 4'h0, 30'h4, 32'h0, WA, 32'h0, 32'd2);
    tbl[5]  = mk(1'b0, 30'h0, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0, 1'b0, 32'h0,
                 1'b1, 1'b1, 1'b0, 4'hF, 30'h100, 32'h0, WA, 32'h0, 32'd3);
    tbl[6]  = mk(1'b0, 30'h0, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0, 1'b0, 32'h0,
                 1'b1, 1'b1, 1'b0, 4'hF, 30'h100, 32'h0, WA, 32'h0, 32'd4);
    tbl[7]  = mk(1'b0, 30'h0, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0, 1'b1, WB,
                 1'b1, 1'b1, 1'b0, 4'hF, 30'h100, 32'h0, WA, 32'h0, 32'd5);
    tbl[8]  = mk(1'b1, 30'h8, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0, 1'b0, 32'h0,
                 1'b1, 1'b1, 1'b0, 4'hF, 30'h8, 32'h0, WA, WB, 32'd6);
    tbl[9]  = mk(1'b1, 30'hC, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0, 1'b0, 32'h0,
                 1'b1, 1'b1, 1'b0, 4'hF, 30'h8, 32'h0, WA, WB, 32'd7);
    tbl[10] = mk(1'b1, 30'hC, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0, 1'b1, WC,
                 1'b1, 1'b1, 1'b0, 4'hF, 30'h8, 32'h0, WA, WB, 32'd8);
    tbl[11] = mk(1'b0, 30'h0, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0, 1'b0, 32'h0,
                 1'b0, 1'b0, 1'b0, 4'h0, 30'h8, 32'h0, WC, WB, 32'd9);
    tbl[12] = mk(1'b0, 30'h0, 1'b1, 1'b0, 4'hF, 30'h40, 32'h0, 1'b1, WD,
                 1'b1, 1'b0, 1'b0, 4'h0, 30'h8, 32'h0, WC, WB, 32'd9);
    tbl[13] = mk(1'b0, 30'h0, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0, 1'b1, WD,
                 1'b1, 1'b1, 1'b0, 4'hF, 30'h40, 32'h0, WC, WB, 32'd10);
    tbl[14] = mk(1'b0, 30'h0, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0, 1'b0, 32'h0,
                 1'b0, 1'b0, 1'b0, 4'h0, 30'h40, 32'h0, WC, WD, 32'd11);
    tbl[15] = mk(1'b0, 30'h0, 1'b1, 1'b1, 4'h4, 30'h20, WS, 1'b0, 32'h0,
                 1'b1, 1'b0, 1'b0, 4'h0, 30'h40, 32'h0, WC, WD, 32'd11);
    tbl[16] = mk(1'b0, 30'h0, 1'b1, 1'b1, 4'h4, 30'h20, 32'hFFFFFFFF, 1'b0, 32'h0,
                 1'b1, 1'b1, 1'b1, 4'h4, 30'h20, WS, WC, WD, 32'd12);
    tbl[17] = mk(1'b0, 30'h0, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0, 1'b1, 32'hDEADBEEF,
                 1'b1, 1'b1, 1'b1, 4'h4, 30'h20, WS, WC, WD, 32'd13);
    tbl[18] = mk(1'b0, 30'h0, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0, 1'b0, 32'h0,
                 1'b0, 1'b0, 1'b0, 4'h0, 30'h20, WS, WC, WD, 32'd14);
    tbl[19] = mk(1'b0, 30'h0, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0, 1'b1, 32'h55555555,
                 1'b0, 1'b0, 1'b0, 4'h0, 30'h20, WS, WC, WD, 32'd14);
    tbl[20] = mk(1'b0, 30'h0, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0, 1'b0, 32'h0,
                 1'b0, 1'b0, 1'b0, 4'h0, 30'h20, WS, WC, WD, 32'd14);

    z = tbl[0];
    drive0(z);
    bus1.if_req    = 1'b0;
    bus1.if_addr   = 30'h0;
    bus1.d_req     = 1'b0;
    bus1.d_we      = 1'b0;
    bus1.d_be      = 4'h0;
    bus1.d_addr    = 30'h0;
    bus1.d_wdata   = 32'h0;
    bus1.mem_ready = 1'b0;
    bus1.mem_rdata = 32'h0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Per-cycle table: fetch-only, load+fetch with waits, load, byte store
    for (int i = 0; i < NV; i++) begin
      drive0(tbl[i]);
      @(negedge clk);
      chk($sformatf("row%0d stall", i),    32'(bus0.stall),    32'(tbl[i].e_stall));
      chk($sformatf("row%0d mem_req", i),  32'(bus0.mem_req),  32'(tbl[i].e_mreq));
      chk($sformatf("row%0d mem_we", i),   32'(bus0.mem_we),   32'(tbl[i].e_mwe));
      chk($sformatf("row%0d mem_be", i),   32'(bus0.mem_be),   32'(tbl[i].e_mbe));
      chk($sformatf("row%0d mem_addr", i), 32'(bus0.mem_addr), 32'(tbl[i].e_maddr));
      chk($sformatf("row%0d mem_wdata", i), bus0.mem_wdata,    tbl[i].e_mwd);
      chk($sformatf("row%0d if_rdata", i), bus0.if_rdata,      tbl[i].e_ifrd);
      chk($sformatf("row%0d d_rdata", i),  bus0.d_rdata,       tbl[i].e_drd);
      chk($sformatf("row%0d stall_cycles", i), bus0.stall_cycles, tbl[i].e_cnt);
      next_cycle();
    end

    // Reset while a load is waiting in D_ACC
    z = tbl[0];
    z.dr = 1'b1; z.be = 4'hF; z.da = 30'h80;
    drive0(z);
    @(negedge clk);
    chk("rst_seq idle stall", 32'(bus0.stall), 32'd1);
    next_cycle();
    z = tbl[0];
    drive0(z);
    @(negedge clk);
    chk("rst_seq dacc mem_req", 32'(bus0.mem_req), 32'd1);
    chk("rst_seq dacc mem_addr", 32'(bus0.mem_addr), 32'h80);
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_seq mem_req", 32'(bus0.mem_req), 32'd0);
    chk("rst_seq mem_be", 32'(bus0.mem_be), 32'd0);
    chk("rst_seq stall", 32'(bus0.stall), 32'd0);
    chk("rst_seq d_rdata", bus0.d_rdata, 32'h0);
    chk("rst_seq if_rdata", bus0.if_rdata, 32'h0);
    chk("rst_seq stall_cycles", bus0.stall_cycles, 32'd0);
    next_cycle();
    z = tbl[0];
    z.ifr = 1'b1; z.ia = 30'h10; z.rdy = 1'b1; z.rd = 32'h11112222;
    drive0(z);
    @(negedge clk);
    chk("rst_seq restart stall", 32'(bus0.stall), 32'd1);
    next_cycle();
    z.ifr = 1'b0;
    drive0(z);
    @(negedge clk);
    chk("rst_seq facc mem_req", 32'(bus0.mem_req), 32'd1);
    chk("rst_seq facc mem_addr", 32'(bus0.mem_addr), 32'h10);
    next_cycle();
    z = tbl[0];
    drive0(z);
    @(negedge clk);
    chk("rst_seq done stall", 32'(bus0.stall), 32'd0);
    chk("rst_seq done if_rdata", bus0.if_rdata, 32'h11112222);
    chk("rst_seq done stall_cycles", bus0.stall_cycles, 32'd2);
    next_cycle();

    // 4-bit stall counter saturates at 15 with a fetch that never completes
    bus1.if_req    = 1'b1;
    bus1.if_addr   = 30'h3;
    bus1.mem_ready = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("sat k=%0d stall_cycles", k), 32'(bus1.stall_cycles),
          (k < 15) ? 32'(k) : 32'd15);
    end
    chk("sat stall held", 32'(bus1.stall), 32'd1);
    chk("sat mem_addr", 32'(bus1.mem_addr), 32'h3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Sequencer that shares one single-ported, variable-latency backing memory between the instruction-fetch (IF) stage and the data-access (MEM) stage of the pipelined MIPS machine. Each pipeline step, it captures the pending fetch and data requests and runs them serially on the memory port, data first and then fetch. It holds the whole pipeline with `stall` until both requests finish, then returns the instruction word and load data. It also counts stall cycles for performance measurement.

## Interface
- `ADDR_W`, 30, word-address width (byte address bits [31:2]).
- `CNT_W`, 32, width of the stall-cycle counter.

Ports:
- `clk` in 1: clock. All state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `if_req` in 1: fetch request for this step.
- `if_addr` in ADDR_W: fetch word address.
- `if_rdata` out 32: last fetched instruction word.
- `d_req` in 1: data request (load or store) for this step.
- `d_we` in 1: 1 = store, 0 = load.
- `d_be` in 4: store byte enables (bit i = byte lane i).
- `d_addr` in ADDR_W: data word address.
- `d_wdata` in 32: store data.
- `d_rdata` out 32: last load result (full word).
- `stall` out 1: pipeline must hold PC and all pipeline registers while 1.
- `mem_req`, `mem_we` out 1: backing-memory request and write strobe.
- `mem_be` out 4: backing-memory byte enables.
- `mem_addr` out ADDR_W: backing-memory word address.
- `mem_wdata` out 32: backing-memory write data.
- `mem_ready` in 1: memory completes the current transfer this cycle.
- `mem_rdata` in 32: read data, valid when `mem_ready`=1.
- `stall_cycles` out CNT_W: saturating count of cycles with `stall`=1.

## Operation
FSM states are IDLE, D_ACC, F_ACC and DONE.

- **IDLE**
  - No request: stay in IDLE, `stall`=0.
  - `if_req` or `d_req` high: capture all request inputs into internal registers and assert `stall`=1 (combinationally, same cycle).
  - Next state is D_ACC if `d_req`, else F_ACC.
- **D_ACC**
  - Drive `mem_req`=1 with the captured `d_we`, `d_be`, `d_addr` and `d_wdata`.
  - On `mem_ready`=1: if a load, write `mem_rdata` into `d_rdata`. A store leaves `d_rdata` unchanged.
  - Next state is F_ACC if a fetch was captured, else DONE.
- **F_ACC**
  - Drive `mem_req`=1, `mem_we`=0, `mem_be`=4'hF and the captured fetch address.
  - On `mem_ready`=1: write `mem_rdata` into `if_rdata` and go to DONE.
- **DONE**
  - `stall`=0 for exactly one cycle; the pipeline advances on this edge.
  - Next state is always IDLE.

Output and capture rules:
- `stall` = (state is D_ACC or F_ACC) or (state is IDLE and (`if_req` or `d_req`)).
- Outside D_ACC and F_ACC: `mem_req`=0, `mem_we`=0, `mem_be`=0. `mem_addr` and `mem_wdata` hold their last values.
- Request inputs are sampled only in IDLE. Changes during D_ACC, F_ACC or DONE are ignored.
- `stall_cycles` increments every cycle `stall`=1 and saturates at 2^CNT_W−1, with no wrap.

## Timing
- Reset (synchronous, takes effect at the edge where `reset`=1):
  - state becomes IDLE;
  - `if_rdata`, `d_rdata`, `stall_cycles` and the captured registers become 0;
  - `mem_req`, `mem_we` and `mem_be` are 0 from the following cycle.
- A reset while in D_ACC or F_ACC abandons the in-flight transfer: `mem_req` drops the next cycle and no result is written. The backing memory must tolerate a dropped request.
- Memory handshake: `mem_req` and its address, data and enables stay stable until the edge where `mem_ready`=1 is sampled. A transfer completes on every such edge.
  - `mem_ready` seen in IDLE or DONE is ignored.
  - Back-to-back D_ACC then F_ACC has no idle cycle between transfers.
- Latency for N memory wait cycles per transfer (`mem_ready` arriving on the (N+1)-th cycle of the access state):
  - fetch only: 1 + (N+1) + 1 cycles, of which `stall`=1 for N+2;
  - data + fetch: 1 + 2(N+1) + 1 cycles, of which `stall`=1 for 2N+3.
- `if_rdata` and `d_rdata` are registered and valid from DONE onward. They hold until the next completing transfer of their own kind.

## Test plan
- **Fetch only, zero wait.**
  - Stimulus: after reset, `if_req`=1, `if_addr`=0x4, `mem_ready`=1, `mem_rdata`=0x2402000A.
  - Response: IDLE `stall`=1, then F_ACC `mem_req`=1 `mem_addr`=0x4, then DONE `stall`=0 with `if_rdata`=0x2402000A; `stall_cycles`=2.
- **Load plus fetch, 2 wait states.**
  - Stimulus: `d_req`=1, `d_we`=0, `d_addr`=0x100, `if_addr`=0x8.
  - Response: `mem_addr`=0x100 for 3 cycles, then 0x8 for 3 cycles; `d_rdata` and `if_rdata` take their respective `mem_rdata`; `stall` high 7 cycles.
- **Byte store.**
  - Stimulus: `d_we`=1, `d_be`=4'b0100, `d_wdata`=0x00AB0000, `d_addr`=0x20, with `d_rdata` previously 0x1234.
  - Response: in D_ACC `mem_we`=1, `mem_be`=4'b0100, `mem_wdata`=0x00AB0000; `d_rdata` stays 0x1234.
- **Inputs changed during stall.**
  - Stimulus: change `if_addr` from 0x8 to 0xC while in F_ACC with `mem_ready`=0.
  - Response: `mem_addr` stays 0x8 until completion.
- **Reset mid-transfer.**
  - Stimulus: assert `reset` during D_ACC, with `mem_ready` never asserted.
  - Response: next cycle `mem_req`=0, `stall`=0, `d_rdata`=0, `stall_cycles`=0, and the next request starts from IDLE.
- **Counter saturation.**
  - Stimulus: `CNT_W`=4, with requests held and `mem_ready`=0 for 20 cycles.
  - Response: `stall_cycles` reaches 15 and holds at 15.
